// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite movers: direction codes, draw FSM states,
// the transparent-colour default and a small clamping helper.
package sprite_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_FLUSH,
      ST_DONE
   } state_e;

   // The transparent colour code is all ones at whatever colour width is used.
   localparam logic DEFAULT_TRANSP_BIT = 1'b1;

   function automatic int clampInt(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/pos_clamp.sv
// Combinational one-step position update: moves by STEP in the given direction
// and saturates to the playfield so the sprite never wraps or leaves the map.
module pos_clamp
   import sprite_pkg::*;
#(
   parameter int X_W   = 8,
   parameter int Y_W   = 8,
   parameter int STEP  = 1,
   parameter int MAX_X = 240,
   parameter int MAX_Y = 160
) (
   input  logic [X_W-1:0] pos_x_i,
   input  logic [Y_W-1:0] pos_y_i,
   input  logic [1:0]     dir_i,
   output logic [X_W-1:0] new_x_o,
   output logic [Y_W-1:0] new_y_o
);

   int nx;
   int ny;

   // Signed integer arithmetic lets a move below zero be seen and clamped.
   always_comb begin
      nx = int'(pos_x_i);
      ny = int'(pos_y_i);
      unique case (dir_i)
         DIR_UP:    ny = ny - STEP;
         DIR_DOWN:  ny = ny + STEP;
         DIR_LEFT:  nx = nx - STEP;
         DIR_RIGHT: nx = nx + STEP;
      endcase
   end

   assign new_x_o = X_W'(clampInt(nx, 0, MAX_X));
   assign new_y_o = Y_W'(clampInt(ny, 0, MAX_Y));

endmodule

// File: rtl/sprite_mover.sv
// Player sprite: tracks position/facing/walk frame from move commands and
// streams one sprite from ROM into the frame buffer on each draw request.
module sprite_mover
   import sprite_pkg::*;
#(
   parameter int MAP_W   = 256,
   parameter int MAP_H   = 176,
   parameter int SPR_W   = 16,
   parameter int SPR_H   = 16,
   parameter int STEP    = 1,
   parameter int FRAMES  = 2,
   parameter int COLOR_W = 6,
   parameter logic [COLOR_W-1:0] TRANSP = {COLOR_W{DEFAULT_TRANSP_BIT}},
   parameter int INIT_X  = 127,
   parameter int INIT_Y  = 88
) (
   input  logic                                           clock,
   input  logic                                           reset,
   input  logic                                           init,
   input  logic                                           attack,
   input  logic                                           move_up,
   input  logic                                           move_down,
   input  logic                                           move_left,
   input  logic                                           move_right,
   input  logic                                           draw_start,
   output logic [$clog2(2*4*FRAMES*SPR_W*SPR_H)-1:0]      rom_addr,
   input  logic [COLOR_W-1:0]                             rom_data,
   output logic [$clog2(MAP_W)-1:0]                       x_draw,
   output logic [$clog2(MAP_H)-1:0]                       y_draw,
   output logic [COLOR_W-1:0]                             colour,
   output logic                                           vga_write,
   output logic                                           draw_done,
   output logic                                           busy,
   output logic [1:0]                                     facing
);

   localparam int X_W  = $clog2(MAP_W);
   localparam int Y_W  = $clog2(MAP_H);
   localparam int PX_W = $clog2(SPR_W);
   localparam int PY_W = $clog2(SPR_H);
   localparam int FR_W = $clog2(FRAMES);

   state_e          state_q, state_d;
   logic [X_W-1:0]  pos_x_q, pos_x_d, draw_x_q, draw_x_d, x_draw_q, x_draw_d, clamp_x;
   logic [Y_W-1:0]  pos_y_q, pos_y_d, draw_y_q, draw_y_d, y_draw_q, y_draw_d, clamp_y;
   logic [1:0]      facing_q, facing_d;
   logic [FR_W-1:0] frame_q, frame_d;
   logic            atk_q, atk_d;
   logic            wr_valid_q, wr_valid_d;
   logic [PX_W-1:0] px_q, px_d;
   logic [PY_W-1:0] py_q, py_d;
   dir_e            move_dir;
   logic            move_any;

   // Among simultaneous move commands, up beats down beats left beats right.
   always_comb begin
      move_any = move_up | move_down | move_left | move_right;
      move_dir = DIR_RIGHT;
      if (move_up)        move_dir = DIR_UP;
      else if (move_down) move_dir = DIR_DOWN;
      else if (move_left) move_dir = DIR_LEFT;
   end

   pos_clamp #(
      .X_W   (X_W),
      .Y_W   (Y_W),
      .STEP  (STEP),
      .MAX_X (MAP_W - SPR_W),
      .MAX_Y (MAP_H - SPR_H)
   ) u_pos_clamp (
      .pos_x_i (pos_x_q),
      .pos_y_i (pos_y_q),
      .dir_i   (move_dir),
      .new_x_o (clamp_x),
      .new_y_o (clamp_y)
   );

   always_comb begin
      state_d    = state_q;
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      facing_d   = facing_q;
      frame_d    = frame_q;
      atk_d      = atk_q;
      draw_x_d   = draw_x_q;
      draw_y_d   = draw_y_q;
      px_d       = px_q;
      py_d       = py_q;
      x_draw_d   = x_draw_q;
      y_draw_d   = y_draw_q;
      wr_valid_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (init) begin
               pos_x_d  = X_W'(INIT_X);
               pos_y_d  = Y_W'(INIT_Y);
               facing_d = DIR_DOWN;
               atk_d    = 1'b0;
            end else if (draw_start) begin
               state_d  = ST_FETCH;
               draw_x_d = pos_x_q;
               draw_y_d = pos_y_q;
               px_d     = '0;
               py_d     = '0;
            end else if (attack) begin
               atk_d = 1'b1;
            end else if (move_any) begin
               pos_x_d  = clamp_x;
               pos_y_d  = clamp_y;
               facing_d = move_dir;
               frame_d  = frame_q + FR_W'(1);
               atk_d    = 1'b0;
            end
         end

         // The coordinate registered here lines up with the ROM word returned next cycle.
         ST_FETCH: begin
            wr_valid_d = 1'b1;
            x_draw_d   = draw_x_q + X_W'(px_q);
            y_draw_d   = draw_y_q + Y_W'(py_q);
            if (px_q == PX_W'(SPR_W - 1)) begin
               px_d = '0;
               if (py_q == PY_W'(SPR_H - 1)) begin
                  py_d    = '0;
                  state_d = ST_FLUSH;
               end else begin
                  py_d = py_q + PY_W'(1);
               end
            end else begin
               px_d = px_q + PX_W'(1);
            end
         end

         ST_FLUSH: state_d = ST_DONE;

         ST_DONE:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pos_x_q    <= X_W'(INIT_X);
         pos_y_q    <= Y_W'(INIT_Y);
         facing_q   <= DIR_DOWN;
         frame_q    <= '0;
         atk_q      <= 1'b0;
         draw_x_q   <= '0;
         draw_y_q   <= '0;
         px_q       <= '0;
         py_q       <= '0;
         x_draw_q   <= '0;
         y_draw_q   <= '0;
         wr_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         facing_q   <= facing_d;
         frame_q    <= frame_d;
         atk_q      <= atk_d;
         draw_x_q   <= draw_x_d;
         draw_y_q   <= draw_y_d;
         px_q       <= px_d;
         py_q       <= py_d;
         x_draw_q   <= x_draw_d;
         y_draw_q   <= y_draw_d;
         wr_valid_q <= wr_valid_d;
      end
   end

   assign rom_addr  = (state_q == ST_FETCH) ? {atk_q, facing_q, frame_q, py_q, px_q} : '0;
   assign x_draw    = x_draw_q;
   assign y_draw    = y_draw_q;
   assign colour    = wr_valid_q ? rom_data : '0;
   assign vga_write = wr_valid_q && (rom_data != TRANSP);
   assign draw_done = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign facing    = facing_q;

endmodule
